// File: rtl/mult_shift_add_unit.sv
// Signed 8x8 -> 16-bit multiplier built from a shift-and-add partial-product
// array, one operand pair per cycle with a registered product and done pulse.
module mult_shift_add_unit (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid,
  input  logic signed [7:0]  a,
  input  logic signed [7:0]  b,
  output logic signed [15:0] product,
  output logic               done
);

  logic signed [15:0] w_aExt;
  logic        [15:0] w_pp [8];
  logic        [15:0] w_sumLow;
  logic        [15:0] w_product;
  logic signed [15:0] r_product;
  logic               r_done;

  assign w_aExt = {{8{a[7]}}, a};

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_pp
      assign w_pp[gi] = b[gi] ? (w_aExt << gi) : 16'd0;
    end
  endgenerate

  // b[7] carries weight -2^7, so its partial product is subtracted
  assign w_sumLow  = w_pp[0] + w_pp[1] + w_pp[2] + w_pp[3]
                   + w_pp[4] + w_pp[5] + w_pp[6];
  assign w_product = w_sumLow - w_pp[7];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_product <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= valid;
      if (valid) begin
        r_product <= w_product;
      end
    end
  end

  assign product = r_product;
  assign done    = r_done;

endmodule

// File: tb/tb_mult_shift_add_unit.sv
// Directed bench for mult_shift_add_unit with hand-computed products.
module tb_mult_shift_add_unit;

  logic               clk;
  logic               rst;
  logic               valid;
  logic signed [7:0]  a;
  logic signed [7:0]  b;
  logic signed [15:0] product;
  logic               done;

  int checks = 0;
  int errors = 0;

  mult_shift_add_unit dut (
    .clk     (clk),
    .rst     (rst),
    .valid   (valid),
    .a       (a),
    .b       (b),
    .product (product),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic signed [16:0] observed,
                             input logic signed [16:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drive inputs on the falling edge, then settle just past the next rising edge
  task automatic applyStimulus(input logic r, input logic v,
                               input logic signed [7:0] aa, input logic signed [7:0] bb);
    @(negedge clk);
    rst   = r;
    valid = v;
    a     = aa;
    b     = bb;
    @(posedge clk);
    #1;
  endtask

  task automatic pulseCheck(input string tag, input logic signed [7:0] aa,
                            input logic signed [7:0] bb, input logic signed [16:0] exp);
    applyStimulus(1'b0, 1'b1, aa, bb);
    checkOutput({tag, "_product"}, 17'(product), exp);
    checkOutput({tag, "_done"}, 17'(done), 17'sd1);
    applyStimulus(1'b0, 1'b0, aa, bb);
    checkOutput({tag, "_hold"}, 17'(product), exp);
    checkOutput({tag, "_doneLow"}, 17'(done), 17'sd0);
  endtask

  typedef struct {
    logic signed [7:0]  va;
    logic signed [7:0]  vb;
    logic signed [16:0] exp;
  } vec_t;

  vec_t basicVec [8];
  vec_t streamVec [4];

  initial begin
    rst = 1'b0; valid = 1'b0; a = '0; b = '0;

    basicVec[0] = '{8'sd10,    8'sd20,   17'sd200};
    basicVec[1] = '{8'sd127,   8'sd127,  17'sd16129};
    basicVec[2] = '{-8'sd5,    8'sd4,   -17'sd20};
    basicVec[3] = '{-8'sd128, -8'sd128,  17'sd16384};
    basicVec[4] = '{-8'sd128,  8'sd127, -17'sd16256};
    basicVec[5] = '{8'sd127,  -8'sd128, -17'sd16256};
    basicVec[6] = '{-8'sd1,   -8'sd1,    17'sd1};
    basicVec[7] = '{8'sd0,    -8'sd128,  17'sd0};

    streamVec[0] = '{8'sd1,   8'sd2,   17'sd2};
    streamVec[1] = '{-8'sd3,  8'sd4,  -17'sd12};
    streamVec[2] = '{8'sd5,  -8'sd6,  -17'sd30};
    streamVec[3] = '{-8'sd7, -8'sd8,   17'sd56};

    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b1, 8'sd5, 8'sd5);
      checkOutput("reset_product", 17'(product), 17'sd0);
      checkOutput("reset_done", 17'(done), 17'sd0);
    end
    applyStimulus(1'b0, 1'b0, 8'sd5, 8'sd5);
    checkOutput("release_product", 17'(product), 17'sd0);
    checkOutput("release_done", 17'(done), 17'sd0);

    for (int i = 0; i < 8; i++) begin
      pulseCheck($sformatf("vec%0d", i), basicVec[i].va, basicVec[i].vb, basicVec[i].exp);
    end

    pulseCheck("hold_setup", 8'sd3, 8'sd7, 17'sd21);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, -8'sd9, 8'sd11);
      checkOutput("hold_product", 17'(product), 17'sd21);
      checkOutput("hold_done", 17'(done), 17'sd0);
    end

    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, streamVec[i].va, streamVec[i].vb);
      checkOutput($sformatf("stream%0d_product", i), 17'(product), streamVec[i].exp);
      checkOutput($sformatf("stream%0d_done", i), 17'(done), 17'sd1);
    end
    applyStimulus(1'b0, 1'b0, 8'sd0, 8'sd0);
    checkOutput("stream_end_done", 17'(done), 17'sd0);
    checkOutput("stream_end_product", 17'(product), 17'sd56);

    applyStimulus(1'b1, 1'b1, 8'sd9, 8'sd9);
    checkOutput("midreset_product", 17'(product), 17'sd0);
    checkOutput("midreset_done", 17'(done), 17'sd0);
    pulseCheck("after_reset", 8'sd9, 8'sd9, 17'sd81);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
